// File: rtl/wishbone_master_ctrl.sv
// -----------------------------------------------------------------------------
// wishbone_master_ctrl
//
// Command-driven Wishbone classic master. A command is either one write beat
// or a read burst of cmd_len_i + 1 beats at incrementing word addresses. Each
// beat produces a single-cycle response pulse. The burst is terminated early
// by err_i (and by a per-beat timeout when that option is enabled).
//
// Optional feature macro: WB_MASTER_TIMEOUT_EN
//   defined   : a beat left unanswered for TIMEOUT stb_o cycles ends as an error
//   undefined : no timeout counter; the master waits indefinitely
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o command handshake (ready only in IDLE)
//   cmd_we_i, cmd_addr_i,   command fields: direction, start byte address,
//   cmd_data_i, cmd_len_i   write data, read beats minus one
//   rsp_valid_o, rsp_data_o,
//   rsp_err_o               per-beat response pulse (no backpressure)
//   addr_o, data_o, we_o,
//   sel_o, cyc_o, stb_o     Wishbone master outputs
//   data_i, ack_i, err_i    Wishbone slave returns
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module wishbone_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_data_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic                rsp_err_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                we_o,
  output logic [DATA_W/8-1:0] sel_o,
  output logic                cyc_o,
  output logic                stb_o,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                ack_i,
  input  logic                err_i
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t           state;
  logic [LEN_W-1:0] beats_left;  // beats still to run after the current one
  logic             slave_resp;
  logic             tmo_hit;
  logic             beat_done;
  logic             beat_err;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Gated by rst_i so the command port reads not-ready while reset is held.
  assign cmd_ready_o = (state == IDLE) && !rst_i;

  always_comb begin
    slave_resp = stb_o && (ack_i || err_i);
`ifdef WB_MASTER_TIMEOUT_EN
    // The counter holds the number of unanswered stb_o cycles already
    // elapsed; the edge closing cycle number TIMEOUT ends the beat.
    tmo_hit = stb_o && !(ack_i || err_i) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    tmo_hit = 1'b0;
`endif
    beat_done = slave_resp || tmo_hit;
    // err_i wins over a simultaneous ack_i
    beat_err  = (stb_o && err_i) || tmo_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      beats_left  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      we_o        <= 1'b0;
      sel_o       <= '0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      sel_o       <= '1;
      rsp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            state      <= BUS;
            cyc_o      <= 1'b1;
            stb_o      <= 1'b1;
            we_o       <= cmd_we_i;
            addr_o     <= cmd_addr_i;
            data_o     <= cmd_we_i ? cmd_data_i : '0;
            // Writes are always a single beat regardless of cmd_len_i.
            beats_left <= cmd_we_i ? '0 : cmd_len_i;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end
        end
        BUS: begin
          if (beat_done) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= beat_err;
            rsp_data_o  <= (we_o || tmo_hit) ? '0 : data_i;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
            if (beat_err || (beats_left == '0)) begin
              // Last beat or any error: release the bus, drop the remainder.
              state  <= IDLE;
              cyc_o  <= 1'b0;
              stb_o  <= 1'b0;
              we_o   <= 1'b0;
              data_o <= '0;
            end else begin
              addr_o     <= addr_o + ADDR_W'(DATA_W / 8);
              beats_left <= beats_left - LEN_W'(1);
            end
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (stb_o) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master_ctrl.sv
`timescale 1ns/1ps

module tb_wishbone_master_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_we_i;
  logic [ADDR_W-1:0]   cmd_addr_i;
  logic [DATA_W-1:0]   cmd_data_i;
  logic [LEN_W-1:0]    cmd_len_i;
  logic                rsp_valid_o;
  logic [DATA_W-1:0]   rsp_data_o;
  logic                rsp_err_o;
  logic [ADDR_W-1:0]   addr_o;
  logic [DATA_W-1:0]   data_o;
  logic                we_o;
  logic [DATA_W/8-1:0] sel_o;
  logic                cyc_o;
  logic                stb_o;
  logic [DATA_W-1:0]   data_i;
  logic                ack_i;
  logic                err_i;

  wishbone_master_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .TIMEOUT(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_data_i (cmd_data_i),
    .cmd_len_i  (cmd_len_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .we_o       (we_o),
    .sel_o      (sel_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .data_i     (data_i),
    .ack_i      (ack_i),
    .err_i      (err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_rsp = 0;
  int   n_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [DATA_W-1:0] d, input logic e);
    exp_q.push_back('{data: d, err: e});
    n_exp++;
  endtask

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rsp_valid_o === 1'b1) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got data 0x%0h err %0b, required no response",
                 rsp_data_o, rsp_err_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data_o), 64'(mon_e.data));
        check("rsp_err", 64'(rsp_err_o), 64'(mon_e.err));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where the
  // first beat is on the bus.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] len);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_data_i  = d;
    cmd_len_i   = len;
    check("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check("cyc_after_accept", 64'(cyc_o), 64'd1);
    check("stb_after_accept", 64'(stb_o), 64'd1);
    check("addr_after_accept", 64'(addr_o), 64'(addr));
  endtask

  // One beat: hold `waits` wait states, then answer with ack/err and data.
  task automatic do_beat(input logic [ADDR_W-1:0] exp_addr, input int waits,
                         input logic a, input logic e,
                         input logic [DATA_W-1:0] rdata, input logic [DATA_W-1:0] exp_d);
    check("beat_stb", 64'(stb_o), 64'd1);
    check("beat_addr", 64'(addr_o), 64'(exp_addr));
    for (int w = 0; w < waits; w++) begin
      @(negedge clk_i);
      check("wait_stb", 64'(stb_o), 64'd1);
      check("wait_addr", 64'(addr_o), 64'(exp_addr));
    end
    ack_i  = a;
    err_i  = e;
    data_i = rdata;
    expect_rsp(exp_d, e);
    @(negedge clk_i);
    ack_i  = 1'b0;
    err_i  = 1'b0;
    data_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0;
    cmd_data_i = '0; cmd_len_i = '0; data_i = '0; ack_i = 1'b0; err_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_cyc", 64'(cyc_o), 64'd0);
    check("rst_stb", 64'(stb_o), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_sel", 64'(sel_o), 64'd0);
    rst_i = 1'b0;
    #1 check("ready_after_release", 64'(cmd_ready_o), 64'd1);
    @(negedge clk_i);

    // Single write, two wait states, cmd_len_i ignored
    issue(1'b1, 32'h100, 32'hDEADBEEF, 8'd5);
    check("wr_we", 64'(we_o), 64'd1);
    check("wr_data_o", 64'(data_o), 64'hDEADBEEF);
    check("wr_sel", 64'(sel_o), 64'hF);
    do_beat(32'h100, 2, 1'b1, 1'b0, 32'h12345678, 32'h0);
    check("wr_cyc_end", 64'(cyc_o), 64'd0);
    check("wr_stb_end", 64'(stb_o), 64'd0);
    check("wr_we_end", 64'(we_o), 64'd0);
    check("wr_ready_end", 64'(cmd_ready_o), 64'd1);
    @(negedge clk_i);

    // Read burst of four, zero-wait
    issue(1'b0, 32'h0, 32'hFFFFFFFF, 8'd3);
    check("rd_we", 64'(we_o), 64'd0);
    check("rd_data_o", 64'(data_o), 64'd0);
    for (int i = 0; i < 4; i++)
      do_beat(ADDR_W'(4 * i), 0, 1'b1, 1'b0, DATA_W'(32'h11 * (i + 1)), DATA_W'(32'h11 * (i + 1)));
    check("rd_cyc_end", 64'(cyc_o), 64'd0);
    @(negedge clk_i);

    // Address wrap at the top of the space
    issue(1'b0, 32'hFFFFFFFC, 32'h0, 8'd1);
    do_beat(32'hFFFFFFFC, 0, 1'b1, 1'b0, 32'hA5, 32'hA5);
    do_beat(32'h00000000, 0, 1'b1, 1'b0, 32'h5A, 32'h5A);
    check("wrap_cyc_end", 64'(cyc_o), 64'd0);
    @(negedge clk_i);

    // Error with ack on beat 2 ends the burst; later ack/err with stb low ignored
    issue(1'b0, 32'h40, 32'h0, 8'd3);
    do_beat(32'h40, 0, 1'b1, 1'b0, 32'h1, 32'h1);
    do_beat(32'h44, 0, 1'b1, 1'b1, 32'h0, 32'h0);
    check("err_cyc_end", 64'(cyc_o), 64'd0);
    check("err_stb_end", 64'(stb_o), 64'd0);
    ack_i = 1'b1; err_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("err_no_more_beats", 64'(cyc_o), 64'd0);
    ack_i = 1'b0; err_i = 1'b0;
    @(negedge clk_i);

    // New command while busy is ignored
    issue(1'b0, 32'h200, 32'h0, 8'd0);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h300;
    do_beat(32'h200, 2, 1'b1, 1'b0, 32'h77, 32'h77);
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
    check("busy_cmd_cyc", 64'(cyc_o), 64'd0);
    @(negedge clk_i);
    check("busy_cmd_not_queued", 64'(cyc_o), 64'd0);

    // Silent slave
    issue(1'b0, 32'h500, 32'h0, 8'd0);
`ifdef WB_MASTER_TIMEOUT_EN
    data_i = 32'hBAD;
    expect_rsp(32'h0, 1'b1);
    repeat (3) begin
      @(negedge clk_i);
      check("tmo_stb_held", 64'(stb_o), 64'd1);
    end
    @(negedge clk_i);
    check("tmo_stb_dropped", 64'(stb_o), 64'd0);
    check("tmo_cyc_dropped", 64'(cyc_o), 64'd0);
    data_i = '0;
    #1 check("tmo_ready", 64'(cmd_ready_o), 64'd1);
    @(negedge clk_i);
`else
    held = 0;
    repeat (110) begin
      @(negedge clk_i);
      if (stb_o === 1'b1) held++;
    end
    check("hold_stb_cycles", 64'(held), 64'd110);
    do_beat(32'h500, 0, 1'b1, 1'b0, 32'h99, 32'h99);
    check("hold_cyc_end", 64'(cyc_o), 64'd0);
    @(negedge clk_i);
`endif

    // Reset during beat 2 of an 8-beat read
    issue(1'b0, 32'h1000, 32'h0, 8'd7);
    do_beat(32'h1000, 0, 1'b1, 1'b0, 32'hAB, 32'hAB);
    check("rstb_beat2_addr", 64'(addr_o), 64'h1004);
    ack_i = 1'b1; data_i = 32'hCD;
    #2 rst_i = 1'b1;
    #1;
    check("rstb_cyc_async", 64'(cyc_o), 64'd0);
    check("rstb_stb_async", 64'(stb_o), 64'd0);
    check("rstb_ready_low", 64'(cmd_ready_o), 64'd0);
    @(negedge clk_i);
    check("rstb_no_rsp", 64'(rsp_valid_o), 64'd0);
    rst_i = 1'b0; ack_i = 1'b0; data_i = '0;
    #1 check("rstb_ready_after", 64'(cmd_ready_o), 64'd1);
    repeat (4) @(negedge clk_i);
    check("rstb_cyc_idle", 64'(cyc_o), 64'd0);

    repeat (3) @(negedge clk_i);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("rsp_count", 64'(n_rsp), 64'(n_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wishbone_master_ctrl.md
WISHBONE_MASTER_CTRL -- requirements
Module: wishbone_master_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, Wishbone address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter LEN_W, default 8, burst length field width.
REQ-004 SHALL have parameter TIMEOUT, default 255, cycles allowed per beat awaiting ack/err.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 cmd_valid_i  in  1  command request.
REQ-008 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-009 cmd_we_i  in  1  1 = write, 0 = read.
REQ-010 cmd_addr_i  in  ADDR_W  start byte address.
REQ-011 cmd_data_i  in  DATA_W  write data.
REQ-012 cmd_len_i  in  LEN_W  read beats minus one.
REQ-013 rsp_valid_o  out  1  one-cycle response pulse per completed beat or termination.
REQ-014 rsp_data_o  out  DATA_W  read data of the beat.
REQ-015 rsp_err_o  out  1  beat ended by err_i or timeout.
REQ-016 addr_o / data_o / we_o / sel_o / cyc_o / stb_o  out  ADDR_W / DATA_W / 1 / DATA_W/8 / 1 / 1  Wishbone classic master outputs.
REQ-017 data_i / ack_i / err_i  in  DATA_W / 1 / 1  Wishbone slave returns.

Function
REQ-018 SHALL implement states IDLE and BUS; cmd_ready_o = (state == IDLE).
REQ-019 On cmd_valid_i && cmd_ready_o, SHALL register cmd fields and enter BUS; cyc_o, stb_o high from the next cycle, addr_o = cmd_addr_i.
REQ-020 Reads: beats = cmd_len_i + 1 (0 -> 1 beat, 2^LEN_W - 1 -> 2^LEN_W beats); writes: always exactly one beat, cmd_len_i ignored.
REQ-021 sel_o SHALL be all ones; data_o = registered cmd_data_i on writes, 0 on reads; we_o = registered cmd_we_i while cyc_o high, else 0.
REQ-022 A beat completes on the rising edge where stb_o && (ack_i || err_i); err_i wins if both high.
REQ-023 On completion SHALL pulse rsp_valid_o the following cycle for exactly one cycle; rsp_data_o = data_i sampled at completion (reads), 0 for writes; rsp_err_o = err condition.
REQ-024 Non-final ack'd read beat: stb_o, cyc_o stay high; addr_o advances by DATA_W/8 in the next cycle, wrapping modulo 2^ADDR_W.
REQ-025 Final beat or any error: cyc_o, stb_o, we_o low next cycle; state IDLE; remaining beats abandoned, no further responses.
REQ-026 ack_i/err_i while stb_o low SHALL be ignored.
REQ-027 cmd_valid_i while BUS SHALL be ignored (not queued).
REQ-028 rsp_valid_o SHALL have no backpressure; consumer always accepts.

Reset
REQ-029 rst_i high SHALL immediately force state IDLE and all outputs 0 (cmd_ready_o = 0 during reset, 1 the first cycle after release).
REQ-030 Reset mid-burst SHALL drop cyc_o/stb_o asynchronously and emit no response for the aborted beat.

Configuration
REQ-031 Macro WB_MASTER_TIMEOUT_EN defined: per-beat counter clears when stb_o rises or a beat completes, increments each stb_o cycle without ack_i/err_i; on reaching TIMEOUT SHALL terminate as error (REQ-023/REQ-025, rsp_data_o = 0).
REQ-032 Macro not defined: no counter; TIMEOUT ignored; master waits indefinitely for ack_i/err_i.

Verification
REQ-033 Single write addr 0x100, data 0xDEADBEEF, ack after 2 wait cycles -> we_o=1, data_o=0xDEADBEEF, one rsp_valid_o, rsp_err_o=0, cyc_o low next cycle.
REQ-034 Read burst addr 0x0, len 3, zero-wait acks with data 0x11..0x44 -> addr_o 0x0,0x4,0x8,0xC on consecutive cycles, four rsp pulses with 0x11,0x22,0x33,0x44.
REQ-035 Read burst addr 0xFFFFFFFC, len 1 -> second beat addr_o = 0x00000000.
REQ-036 Read burst len 3, err_i with ack_i on beat 2 -> two rsp pulses, second rsp_err_o=1, cyc_o low, no beats 3-4.
REQ-037 WB_MASTER_TIMEOUT_EN, TIMEOUT=4, slave never acks -> rsp_valid_o with rsp_err_o=1 after 4 stb cycles, return IDLE; without macro, stb_o held >100 cycles.
REQ-038 rst_i pulse during beat 2 of len-7 read -> cyc_o/stb_o low same cycle, no rsp, cmd_ready_o=1 after release.
